// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if
// Bundles the controller <-> datapath signals of the multicycle MIPS core.
//   op, funct      : instruction fields from the instruction register
//   irq            : external interrupt request (1-cycle pulse is enough)
//   aluControl     : 00 add, 01 sub, 10 and, 11 or
//   aluSrcA/B      : ALU operand selects
//   pcSource       : 00 ALU result, 01 aluOut, 10 jump target
//   PCWrite .. isInterrupted : datapath strobes and selects
//   illegalOp      : unsupported instruction seen in DECODE
//   state          : current controller state code, for debug
// master = the control unit, slave = the datapath.
interface multicycle_control_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       irq;
  logic [1:0] aluControl;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] pcSource;
  logic       PCWrite;
  logic       isBranch;
  logic       lorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       isInterrupted;
  logic       illegalOp;
  logic [3:0] state;

  modport master (
    input  op, funct, irq,
    output aluControl, aluSrcA, aluSrcB, pcSource, PCWrite, isBranch, lorD,
           MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, isInterrupted,
           illegalOp, state
  );

  modport slave (
    output op, funct, irq,
    input  aluControl, aluSrcA, aluSrcB, pcSource, PCWrite, isBranch, lorD,
           MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, isInterrupted,
           illegalOp, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Moore-style main control unit of the multicycle MIPS core. Sequences
// fetch / decode / execute / memory / writeback, and inserts a vector-fetch
// cycle (INTR) at an instruction boundary when an interrupt is pending.
// Ports:
//   clk   : single clock, rising-edge
//   reset : asynchronous, active-high; forces IDLE and all outputs low at once
//   bus   : multicycle_control_fsm_if.master (instruction fields, irq in;
//           all datapath strobes/selects and debug state out)
// Parameter:
//   IRQ_ENABLE : 0 ignores irq entirely (pending latch never sets)
module multicycle_control_fsm #(
  parameter bit IRQ_ENABLE = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  multicycle_control_fsm_if.master       bus
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] FETCH  = 4'd1;
  localparam logic [3:0] DECODE = 4'd2;
  localparam logic [3:0] MEMADR = 4'd3;
  localparam logic [3:0] MEMRD  = 4'd4;
  localparam logic [3:0] MEMWB  = 4'd5;
  localparam logic [3:0] MEMWR  = 4'd6;
  localparam logic [3:0] EXEC   = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;
  localparam logic [3:0] JUMP   = 4'd12;
  localparam logic [3:0] INTR   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  logic [3:0] state_r;
  logic [3:0] nextState_s;
  logic [3:0] endState_s;
  logic       irqPending_r;
  logic       irqReq_s;
  logic       isStore_r;
  logic       rtypeLegal_s;

  assign irqReq_s = IRQ_ENABLE ? bus.irq : 1'b0;

  // A request arriving in the last cycle of an instruction is taken at that
  // same boundary, so the live request is folded in with the latched one.
  assign endState_s = (irqPending_r || irqReq_s) ? INTR : FETCH;

  // Supported R-type function codes.
  always_comb begin
    rtypeLegal_s = 1'b0;
    case (bus.funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR: rtypeLegal_s = 1'b1;
      default:                       rtypeLegal_s = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    nextState_s = IDLE;
    case (state_r)
      IDLE:   nextState_s = FETCH;
      FETCH:  nextState_s = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: nextState_s = MEMADR;
          OP_RTYPE: begin
            if (rtypeLegal_s) begin
              nextState_s = EXEC;
            end else begin
              nextState_s = endState_s;
            end
          end
          OP_BEQ:  nextState_s = BRANCH;
          OP_ADDI: nextState_s = ADDIEX;
          OP_J:    nextState_s = JUMP;
          default: nextState_s = endState_s;
        endcase
      end
      // lw/sw choice was captured in DECODE; op is not looked at here.
      MEMADR: nextState_s = isStore_r ? MEMWR : MEMRD;
      MEMRD:  nextState_s = MEMWB;
      MEMWB:  nextState_s = endState_s;
      MEMWR:  nextState_s = endState_s;
      EXEC:   nextState_s = ALUWB;
      ALUWB:  nextState_s = endState_s;
      BRANCH: nextState_s = endState_s;
      ADDIEX: nextState_s = ADDIWB;
      ADDIWB: nextState_s = endState_s;
      JUMP:   nextState_s = endState_s;
      INTR:   nextState_s = DECODE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Captures whether the decoded memory instruction is a store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isStore_r <= 1'b0;
    end else if (state_r == DECODE) begin
      isStore_r <= (bus.op == OP_SW);
    end else begin
      isStore_r <= isStore_r;
    end
  end

  // Pending-interrupt latch. Entering INTR consumes the latched request; a
  // fresh request on that same edge keeps it set. A request that arrived in
  // the final cycle with nothing latched is the one being serviced, so it
  // does not remain pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqPending_r <= 1'b0;
    end else if (nextState_s == INTR) begin
      irqPending_r <= irqPending_r & irqReq_s;
    end else if (irqReq_s) begin
      irqPending_r <= 1'b1;
    end else begin
      irqPending_r <= irqPending_r;
    end
  end

  assign bus.state = state_r;

  // Moore output decode; aluControl (EXEC) and illegalOp (DECODE) also look
  // at the instruction fields.
  always_comb begin
    bus.aluControl    = 2'b00;
    bus.aluSrcA       = 1'b0;
    bus.aluSrcB       = 2'b00;
    bus.pcSource      = 2'b00;
    bus.PCWrite       = 1'b0;
    bus.isBranch      = 1'b0;
    bus.lorD          = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.RegDst        = 1'b0;
    bus.MemtoReg      = 1'b0;
    bus.isInterrupted = 1'b0;
    bus.illegalOp     = 1'b0;
    case (state_r)
      FETCH: begin
        bus.aluSrcB = 2'b01;
        bus.IRWrite = 1'b1;
        bus.PCWrite = 1'b1;
      end
      DECODE: begin
        bus.aluSrcB = 2'b11;
        case (bus.op)
          OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: bus.illegalOp = 1'b0;
          OP_RTYPE: bus.illegalOp = ~rtypeLegal_s;
          default:  bus.illegalOp = 1'b1;
        endcase
      end
      MEMADR: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
      end
      MEMRD: bus.lorD = 1'b1;
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      MEMWR: begin
        bus.lorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      EXEC: begin
        bus.aluSrcA = 1'b1;
        case (bus.funct)
          FN_ADD:  bus.aluControl = 2'b00;
          FN_SUB:  bus.aluControl = 2'b01;
          FN_AND:  bus.aluControl = 2'b10;
          FN_OR:   bus.aluControl = 2'b11;
          default: bus.aluControl = 2'b00;
        endcase
      end
      ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      BRANCH: begin
        bus.aluSrcA    = 1'b1;
        bus.aluControl = 2'b01;
        bus.pcSource   = 2'b01;
        bus.isBranch   = 1'b1;
      end
      ADDIEX: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
      end
      ADDIWB: bus.RegWrite = 1'b1;
      JUMP: begin
        bus.pcSource = 2'b10;
        bus.PCWrite  = 1'b1;
      end
      // Vector fetch: load IR but leave the PC alone so the real PC survives.
      INTR: begin
        bus.isInterrupted = 1'b1;
        bus.IRWrite       = 1'b1;
      end
      default: bus.aluControl = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm: directed per-cycle vectors. The
// stimulus process pushes the hand-derived expected state and control word
// for each cycle into a queue; a monitor pops and compares on the falling edge.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic reset;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.IRQ_ENABLE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] st;
    logic [16:0] ctl;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  logic [16:0] actCtl;
  assign actCtl = {bus.aluControl, bus.aluSrcA, bus.aluSrcB, bus.pcSource,
                   bus.PCWrite, bus.isBranch, bus.lorD, bus.MemWrite,
                   bus.IRWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg,
                   bus.isInterrupted, bus.illegalOp};

  // Expected control word per state, straight from the state table.
  function automatic logic [16:0] ctlFor(input logic [3:0] s, input logic [1:0] aluc,
                                         input logic ill);
    logic [1:0] ac, srcB, pcs;
    logic srcA, pcw, br, lord, mw, irw, rw, rd, m2r, intr, il;
    ac = 2'b00; srcB = 2'b00; pcs = 2'b00;
    srcA = 1'b0; pcw = 1'b0; br = 1'b0; lord = 1'b0; mw = 1'b0; irw = 1'b0;
    rw = 1'b0; rd = 1'b0; m2r = 1'b0; intr = 1'b0; il = 1'b0;
    case (s)
      4'd1:  begin srcB = 2'b01; irw = 1'b1; pcw = 1'b1; end
      4'd2:  begin srcB = 2'b11; il = ill; end
      4'd3:  begin srcA = 1'b1; srcB = 2'b10; end
      4'd4:  lord = 1'b1;
      4'd5:  begin m2r = 1'b1; rw = 1'b1; end
      4'd6:  begin lord = 1'b1; mw = 1'b1; end
      4'd7:  begin srcA = 1'b1; ac = aluc; end
      4'd8:  begin rd = 1'b1; rw = 1'b1; end
      4'd9:  begin srcA = 1'b1; ac = 2'b01; pcs = 2'b01; br = 1'b1; end
      4'd10: begin srcA = 1'b1; srcB = 2'b10; end
      4'd11: rw = 1'b1;
      4'd12: begin pcs = 2'b10; pcw = 1'b1; end
      4'd13: begin intr = 1'b1; irw = 1'b1; end
      default: ac = 2'b00;
    endcase
    return {ac, srcA, srcB, pcs, pcw, br, lord, mw, irw, rw, rd, m2r, intr, il};
  endfunction

  // One clock of stimulus: drive inputs for the cycle and queue its expectation.
  task automatic cyc(input string name, input logic [3:0] st, input logic [5:0] o,
                     input logic [5:0] f, input logic i, input logic [1:0] aluc,
                     input logic ill);
    @(posedge clk);
    #1;
    bus.op    = o;
    bus.funct = f;
    bus.irq   = i;
    q.push_back('{name, st, ctlFor(st, aluc, ill)});
  endtask

  // Immediate comparison, used where no clock edge may be involved.
  task automatic chkNow(input string name, input logic [3:0] st, input logic [16:0] ctl);
    checks++;
    if (bus.state !== st || actCtl !== ctl) begin
      errors++;
      $display("FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
               name, bus.state, actCtl, st, ctl);
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation each cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (bus.state !== e.st || actCtl !== e.ctl) begin
        errors++;
        $display("FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                 e.name, bus.state, actCtl, e.st, e.ctl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.op    = 6'h00;
    bus.funct = 6'h00;
    bus.irq   = 1'b0;
    #2;
    chkNow("reset_async", 4'd0, 17'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.push_back('{"reset_idle", 4'd0, 17'd0});

    // lw: op is garbage after DECODE to show it is not re-read
    cyc("lw_fetch",  4'd1, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("lw_decode", 4'd2, 6'h23, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("lw_memadr", 4'd3, 6'h2B, 6'h3F, 1'b0, 2'b00, 1'b0);
    cyc("lw_memrd",  4'd4, 6'h3F, 6'h3F, 1'b0, 2'b00, 1'b0);
    cyc("lw_memwb",  4'd5, 6'h3F, 6'h3F, 1'b0, 2'b00, 1'b0);
    // sw
    cyc("sw_fetch",  4'd1, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("sw_decode", 4'd2, 6'h2B, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("sw_memadr", 4'd3, 6'h23, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("sw_memwr",  4'd6, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    // R-type sub / or / and / add
    cyc("sub_fetch",  4'd1, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("sub_decode", 4'd2, 6'h00, 6'h22, 1'b0, 2'b00, 1'b0);
    cyc("sub_exec",   4'd7, 6'h00, 6'h22, 1'b0, 2'b01, 1'b0);
    cyc("sub_aluwb",  4'd8, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("or_fetch",   4'd1, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("or_decode",  4'd2, 6'h00, 6'h25, 1'b0, 2'b00, 1'b0);
    cyc("or_exec",    4'd7, 6'h00, 6'h25, 1'b0, 2'b11, 1'b0);
    cyc("or_aluwb",   4'd8, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("and_fetch",  4'd1, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("and_decode", 4'd2, 6'h00, 6'h24, 1'b0, 2'b00, 1'b0);
    cyc("and_exec",   4'd7, 6'h00, 6'h24, 1'b0, 2'b10, 1'b0);
    cyc("and_aluwb",  4'd8, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    // R-type with unsupported funct: illegal, 2 cycles
    cyc("badfn_fetch",  4'd1, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("badfn_decode", 4'd2, 6'h00, 6'h21, 1'b0, 2'b00, 1'b1);
    // beq
    cyc("beq_fetch",  4'd1, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("beq_decode", 4'd2, 6'h04, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("beq_branch", 4'd9, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    // addi
    cyc("addi_fetch",  4'd1,  6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("addi_decode", 4'd2,  6'h08, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("addi_ex",     4'd10, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("addi_wb",     4'd11, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    // j
    cyc("j_fetch",  4'd1,  6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("j_decode", 4'd2,  6'h02, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("j_jump",   4'd12, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    // illegal opcode
    cyc("ill_fetch",  4'd1, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("ill_decode", 4'd2, 6'h3F, 6'h00, 1'b0, 2'b00, 1'b1);
    // irq pulse during MEMRD of lw: taken after MEMWB, then vector j
    cyc("irq_fetch",  4'd1,  6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("irq_decode", 4'd2,  6'h23, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("irq_memadr", 4'd3,  6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("irq_memrd",  4'd4,  6'h00, 6'h00, 1'b1, 2'b00, 1'b0);
    cyc("irq_memwb",  4'd5,  6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("irq_intr",   4'd13, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("vec_decode", 4'd2,  6'h02, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("vec_jump",   4'd12, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    // pending flag was consumed: next boundary is a plain FETCH
    cyc("post_fetch",  4'd1, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("post_decode", 4'd2, 6'h04, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("post_branch", 4'd9, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    // irq in the final cycle (ALUWB) is taken at that boundary
    cyc("late_fetch",  4'd1,  6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("late_decode", 4'd2,  6'h00, 6'h20, 1'b0, 2'b00, 1'b0);
    cyc("late_exec",   4'd7,  6'h00, 6'h20, 1'b0, 2'b00, 1'b0);
    cyc("late_aluwb",  4'd8,  6'h00, 6'h00, 1'b1, 2'b00, 1'b0);
    cyc("late_intr",   4'd13, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    // vector is a sw; reset arrives in the middle of MEMWR
    cyc("rst_decode", 4'd2, 6'h2B, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("rst_memadr", 4'd3, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    chkNow("rst_memwr_before", 4'd6, ctlFor(4'd6, 2'b00, 1'b0));
    reset = 1'b1;
    #1;
    chkNow("rst_memwr_after", 4'd0, 17'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.push_back('{"rst_idle", 4'd0, 17'd0});
    cyc("rel_fetch",  4'd1,  6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("rel_decode", 4'd2,  6'h02, 6'h00, 1'b0, 2'b00, 1'b0);
    cyc("rel_jump",   4'd12, 6'h00, 6'h00, 1'b0, 2'b00, 1'b0);

    for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit for the multicycle MIPS core. It is a Moore-style state machine that reads `op` and `funct` from the datapath's instruction register and drives every datapath strobe and mux select for each phase of fetch, decode, execute, memory and writeback. It also latches external interrupt requests and inserts a vector-fetch cycle between instructions.

## Interface
- `IRQ_ENABLE`, default 1: when 0, `irq` is ignored and the pending latch never sets.
- `clk` input, 1 bit: single clock. All state changes happen on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `op` input, 6 bits: instruction bits [31:26].
- `funct` input, 6 bits: instruction bits [5:0].
- `irq` input, 1 bit: interrupt request. A 1-cycle pulse is sufficient.
- `aluControl` output, 2 bits: 00 add, 01 sub, 10 and, 11 or.
- `aluSrcA` output, 1 bit: 0 selects PC, 1 selects register A.
- `aluSrcB` output, 2 bits: 00 register B, 01 constant 4, 10 signImm, 11 signImm<<2.
- `pcSource` output, 2 bits: 00 ALU result, 01 aluOut, 10 jump target.
- `PCWrite`, `isBranch`, `lorD`, `MemWrite`, `IRWrite`, `RegWrite`, `RegDst`, `MemtoReg`, `isInterrupted` outputs, 1 bit each: datapath strobes and selects.
- `illegalOp` output, 1 bit: high for the DECODE cycle of an unsupported instruction.
- `state` output, 4 bits: current state code, for debug.

## Operation
- State codes: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, ADDIEX 10, ADDIWB 11, JUMP 12, INTR 13.
- Outputs not listed for a state are 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: aluSrcB=01, IRWrite=1, PCWrite=1. Next is DECODE.
- DECODE: aluSrcB=11 (branch target into aluOut). Next state by `op`:
  - 0x23 (lw) or 0x2B (sw) → MEMADR.
  - 0x00 → EXEC, but only if `funct` is 0x20, 0x22, 0x24 or 0x25.
  - 0x04 (beq) → BRANCH.
  - 0x08 (addi) → ADDIEX.
  - 0x02 (j) → JUMP.
  - Anything else: illegalOp=1 and the instruction ends.
- MEMADR: aluSrcA=1, aluSrcB=10. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: lorD=1. Next is MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1 (RegDst=0). The instruction ends.
- MEMWR: lorD=1, MemWrite=1. The instruction ends.
- EXEC: aluSrcA=1, aluSrcB=00. aluControl comes from `funct`: 0x20→00, 0x22→01, 0x24→10, 0x25→11. Next is ALUWB.
- ALUWB: RegDst=1, RegWrite=1. The instruction ends.
- BRANCH: aluSrcA=1, aluControl=01, pcSource=01, isBranch=1. The instruction ends.
- ADDIEX: aluSrcA=1, aluSrcB=10. Next is ADDIWB.
- ADDIWB: RegWrite=1. The instruction ends.
- JUMP: pcSource=10, PCWrite=1. The instruction ends.
- INTR: isInterrupted=1, IRWrite=1, PCWrite=0. The vector instruction is loaded and the saved PC is unchanged. Next is DECODE.
  - The vector instruction then executes normally; it is normally a `j` to the handler.
  - The DECODE that follows uses the real PC.
- Instruction end: next state is INTR if irqPending is set, otherwise FETCH.
- irqPending flag:
  - Sets on any cycle with `irq`=1 and IRQ_ENABLE=1.
  - Clears on the edge that enters INTR.
  - If `irq`=1 on that same edge, the flag stays set (a new request wins).
  - An interrupt is taken only at an instruction boundary; an instruction is never aborted.
- `op` and `funct` are read only in DECODE and EXEC. Their values in other states are don't-care.

## Timing
- Reset: state=IDLE, irqPending=0, all outputs 0. These take effect immediately on `reset` rising, with no clock needed.
- The first FETCH occurs on the first clock edge after `reset` falls.
- Cycles per instruction, counting FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- An interrupt entry adds 1 cycle (INTR), which replaces FETCH.
- Outputs are combinational from `state`, except:
  - aluControl in EXEC, which also depends on `funct`.
  - illegalOp in DECODE, which also depends on `op` and `funct`.
- Reset asserted mid-instruction: go to IDLE at once. Strobes drop within the same cycle, so no partial MemWrite or RegWrite occurs after reset rises.
- An `irq` arriving during the final cycle of an instruction is taken at that boundary.

## Test plan
- Reset, then release: `state`=0 and all outputs 0 during reset. Cycle 1 is FETCH with PCWrite=1, IRWrite=1, aluSrcB=01. Cycle 2 is DECODE.
- lw, `op`=0x23: states go 1,2,3,4,5,1. MemWrite=0 throughout. RegWrite=1 with MemtoReg=1 only in MEMWB.
- R-type, `op`=0: `funct`=0x22 gives aluControl=01 in EXEC. `funct`=0x25 gives 11. ALUWB has RegDst=1, RegWrite=1.
- beq, `op`=0x04: BRANCH has isBranch=1, pcSource=01, aluControl=01, PCWrite=0. The next state is FETCH.
- `irq` pulse during MEMRD of lw: MEMWB is followed by INTR with isInterrupted=1, IRWrite=1, PCWrite=0, then DECODE. irqPending reads 0 after INTR.
- `op`=0x3F: illegalOp=1 in DECODE, no RegWrite or MemWrite, next state FETCH.
- `reset` asserted during MEMWR: MemWrite drops in the same cycle and `state`=0.
